// File: rtl/jtbubl_romslot.sv
// SDRAM-side responder for a 32-bit graphics ROM port: one-entry cache, one SDRAM request
// per miss, two 16-bit beats assembled into the cached word.
module jtbubl_romslot #(
    parameter int unsigned    AW     = 18,
    parameter int unsigned    SDW    = 22,
    parameter logic [SDW-1:0] OFFSET = '0
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           downloading,
    input  logic           rom_cs,
    input  logic [AW-1:0]  rom_addr,
    output logic [31:0]    rom_data,
    output logic           rom_ok,
    output logic           sdram_req,
    output logic [SDW-1:0] sdram_addr,
    input  logic           sdram_ack,
    input  logic           data_dst,
    input  logic [15:0]    data_read
);

    typedef enum logic [1:0] {StIdle, StReq, StWait0, StWait1} state_e;

    state_e         r_state, w_state_d;
    logic           r_valid, w_valid_d;
    logic [AW-1:0]  r_cache_addr, w_cache_addr_d;
    logic [AW-1:0]  r_req_addr, w_req_addr_d;
    logic [31:0]    r_data, w_data_d;
    logic [15:0]    r_low, w_low_d;
    logic           r_req, w_req_d;
    logic [SDW-1:0] r_sdram_addr, w_sdram_addr_d;

    logic           w_hit;
    logic [SDW-1:0] w_miss_sdaddr;

    assign w_hit         = r_valid && (rom_addr == r_cache_addr);
    // Client words are two SDRAM words wide; the sum wraps modulo 2^SDW.
    assign w_miss_sdaddr = OFFSET + SDW'({rom_addr, 1'b0});

    always_comb begin
        w_state_d      = r_state;
        w_valid_d      = r_valid;
        w_cache_addr_d = r_cache_addr;
        w_req_addr_d   = r_req_addr;
        w_data_d       = r_data;
        w_low_d        = r_low;
        w_req_d        = r_req;
        w_sdram_addr_d = r_sdram_addr;
        if (downloading) begin
            w_valid_d = 1'b0;
            w_req_d   = 1'b0;
            w_state_d = StIdle;
        end else begin
            unique case (r_state)
                StIdle: begin
                    if (rom_cs && !w_hit) begin
                        w_req_addr_d   = rom_addr;
                        w_sdram_addr_d = w_miss_sdaddr;
                        w_req_d        = 1'b1;
                        w_state_d      = StReq;
                    end
                end
                StReq: begin
                    if (sdram_ack) begin
                        w_req_d   = 1'b0;
                        w_state_d = StWait0;
                        // The controller may deliver the first beat with the ack.
                        if (data_dst) begin
                            w_low_d   = data_read;
                            w_state_d = StWait1;
                        end
                    end
                end
                StWait0: begin
                    if (data_dst) begin
                        w_low_d   = data_read;
                        w_state_d = StWait1;
                    end
                end
                StWait1: begin
                    if (data_dst) begin
                        w_data_d       = {data_read, r_low};
                        w_cache_addr_d = r_req_addr;
                        w_valid_d      = 1'b1;
                        w_state_d      = StIdle;
                    end
                end
                default: w_state_d = StIdle;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= StIdle;
            r_valid      <= 1'b0;
            r_cache_addr <= '0;
            r_req_addr   <= '0;
            r_data       <= '0;
            r_low        <= '0;
            r_req        <= 1'b0;
            r_sdram_addr <= '0;
        end else begin
            r_state      <= w_state_d;
            r_valid      <= w_valid_d;
            r_cache_addr <= w_cache_addr_d;
            r_req_addr   <= w_req_addr_d;
            r_data       <= w_data_d;
            r_low        <= w_low_d;
            r_req        <= w_req_d;
            r_sdram_addr <= w_sdram_addr_d;
        end
    end

    assign rom_ok     = rom_cs && w_hit;
    assign rom_data   = r_data;
    assign sdram_req  = r_req;
    assign sdram_addr = r_sdram_addr;

endmodule

// File: tb/tb_jtbubl_romslot.sv
// Bench for jtbubl_romslot: transaction-level cache model checked every cycle, plus directed
// scenarios with literal expectations.
module tb_jtbubl_romslot;

    localparam logic [21:0] OFFSET = 22'h0;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        downloading;
    logic        rom_cs;
    logic [17:0] rom_addr;
    logic [31:0] rom_data;
    logic        rom_ok;
    logic        sdram_req;
    logic [21:0] sdram_addr;
    logic        sdram_ack;
    logic        data_dst;
    logic [15:0] data_read;

    int total = 0;
    int bad   = 0;
    bit run   = 1'b0;

    jtbubl_romslot #(.AW(18), .SDW(22), .OFFSET(OFFSET)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .downloading (downloading),
        .rom_cs      (rom_cs),
        .rom_addr    (rom_addr),
        .rom_data    (rom_data),
        .rom_ok      (rom_ok),
        .sdram_req   (sdram_req),
        .sdram_addr  (sdram_addr),
        .sdram_ack   (sdram_ack),
        .data_dst    (data_dst),
        .data_read   (data_read)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: cache entry plus an in-flight fetch (accepted or not, beats seen so far).
    logic        m_valid, m_fetch, m_req;
    logic [17:0] m_cache, m_raddr;
    logic [31:0] m_data;
    logic [15:0] m_lo;
    logic [21:0] m_sdaddr;
    int          m_nbeats;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_valid  <= 1'b0;
            m_fetch  <= 1'b0;
            m_req    <= 1'b0;
            m_cache  <= '0;
            m_raddr  <= '0;
            m_data   <= '0;
            m_lo     <= '0;
            m_sdaddr <= '0;
            m_nbeats <= 0;
        end else if (downloading) begin
            m_valid <= 1'b0;
            m_req   <= 1'b0;
            m_fetch <= 1'b0;
        end else if (!m_fetch) begin
            if (rom_cs && !(m_valid && rom_addr == m_cache)) begin
                m_fetch  <= 1'b1;
                m_req    <= 1'b1;
                m_raddr  <= rom_addr;
                m_sdaddr <= 22'((longint'(rom_addr) * 2 + longint'(OFFSET)) % (64'd1 << 22));
                m_nbeats <= 0;
            end
        end else begin
            if (m_req && sdram_ack) m_req <= 1'b0;
            // A beat belongs to this fetch once the request has been (or is being) accepted.
            if (data_dst && (!m_req || sdram_ack)) begin
                if (m_nbeats == 0) begin
                    m_lo     <= data_read;
                    m_nbeats <= 1;
                end else begin
                    m_data  <= {data_read, m_lo};
                    m_cache <= m_raddr;
                    m_valid <= 1'b1;
                    m_fetch <= 1'b0;
                end
            end
        end
    end

    always @(negedge clk) begin
        if (run) begin
            chk("model rom_ok", {31'd0, rom_ok}, {31'd0, rom_cs && m_valid && rom_addr == m_cache});
            chk("model rom_data", rom_data, m_data);
            chk("model sdram_req", {31'd0, sdram_req}, {31'd0, m_req});
            chk("model sdram_addr", {10'd0, sdram_addr}, {10'd0, m_sdaddr});
        end
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic beat(input logic [15:0] d);
        data_dst  = 1'b1;
        data_read = d;
        tick();
        data_dst  = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0; downloading = 1'b0; rom_cs = 1'b0; rom_addr = '0;
        sdram_ack = 1'b0; data_dst = 1'b0; data_read = '0;
        tick();
        #1;
        chk("reset rom_data", rom_data, 32'h0);
        chk("reset sdram_req", {31'd0, sdram_req}, 32'h0);
        chk("reset sdram_addr", {10'd0, sdram_addr}, 32'h0);
        rst_n = 1'b1;
        run   = 1'b1;
        tick();

        // Miss on 0x10, ack after three cycles, two beats.
        rom_cs = 1'b1; rom_addr = 18'h10; #1;
        chk("miss no ok", {31'd0, rom_ok}, 32'h0);
        chk("miss req not yet", {31'd0, sdram_req}, 32'h0);
        tick();
        chk("miss req", {31'd0, sdram_req}, 32'h1);
        chk("miss addr", {10'd0, sdram_addr}, 32'h20);
        tick(); tick();
        chk("req held", {31'd0, sdram_req}, 32'h1);
        sdram_ack = 1'b1; tick(); sdram_ack = 1'b0; #1;
        chk("req dropped on ack", {31'd0, sdram_req}, 32'h0);
        beat(16'h1234);
        tick();
        data_dst = 1'b1; data_read = 16'hABCD; #1;
        chk("ok before 2nd beat", {31'd0, rom_ok}, 32'h0);
        tick(); data_dst = 1'b0; #1;
        chk("fill ok", {31'd0, rom_ok}, 32'h1);
        chk("fill data", rom_data, 32'hABCD1234);

        // Hit: zero latency, no SDRAM traffic; never ok without cs.
        rom_cs = 1'b0; #1;
        chk("no ok without cs", {31'd0, rom_ok}, 32'h0);
        tick();
        rom_cs = 1'b1; #1;
        chk("hit ok", {31'd0, rom_ok}, 32'h1);
        tick(); tick();
        chk("hit no req", {31'd0, sdram_req}, 32'h0);

        // Invalidate, then change address mid-fetch.
        downloading = 1'b1; tick(); downloading = 1'b0; #1;
        chk("dl invalidates", {31'd0, rom_ok}, 32'h0);
        tick();
        chk("refetch req", {31'd0, sdram_req}, 32'h1);
        sdram_ack = 1'b1; tick(); sdram_ack = 1'b0;
        rom_addr = 18'h11;
        tick();
        beat(16'h1111);
        data_dst = 1'b1; data_read = 16'h2222; tick(); data_dst = 1'b0; #1;
        chk("stale fill no ok", {31'd0, rom_ok}, 32'h0);
        chk("stale fill no req yet", {31'd0, sdram_req}, 32'h0);
        chk("stale fill data", rom_data, 32'h22221111);
        tick();
        chk("next miss req", {31'd0, sdram_req}, 32'h1);
        chk("next miss addr", {10'd0, sdram_addr}, 32'h22);

        // Ack and first beat together.
        sdram_ack = 1'b1; data_dst = 1'b1; data_read = 16'h5555;
        tick(); sdram_ack = 1'b0; data_dst = 1'b0; #1;
        chk("ack+beat ok low", {31'd0, rom_ok}, 32'h0);
        beat(16'h6666); #1;
        chk("ack+beat ok", {31'd0, rom_ok}, 32'h1);
        chk("ack+beat data", rom_data, 32'h66665555);

        // Downloading mid-REQ.
        rom_addr = 18'h30; tick();
        chk("dl pre req", {31'd0, sdram_req}, 32'h1);
        downloading = 1'b1; tick();
        chk("dl drops req", {31'd0, sdram_req}, 32'h0);
        tick();
        chk("dl holds req low", {31'd0, sdram_req}, 32'h0);
        downloading = 1'b0; rom_addr = 18'h11; #1;
        chk("dl cleared valid", {31'd0, rom_ok}, 32'h0);
        tick();
        chk("dl refetch", {31'd0, sdram_req}, 32'h1);
        chk("dl refetch addr", {10'd0, sdram_addr}, 32'h22);
        sdram_ack = 1'b1; tick(); sdram_ack = 1'b0;
        beat(16'h7777);
        beat(16'h8888); #1;
        chk("dl refetch data", rom_data, 32'h88887777);
        chk("dl refetch ok", {31'd0, rom_ok}, 32'h1);

        // Reset mid-WAIT0, late beats ignored.
        rom_addr = 18'h40; tick();
        sdram_ack = 1'b1; tick(); sdram_ack = 1'b0;
        rst_n = 1'b0; #1;
        chk("async rst data", rom_data, 32'h0);
        chk("async rst req", {31'd0, sdram_req}, 32'h0);
        chk("async rst addr", {10'd0, sdram_addr}, 32'h0);
        chk("async rst ok", {31'd0, rom_ok}, 32'h0);
        tick();
        rst_n = 1'b1; rom_cs = 1'b0;
        beat(16'h9999);
        beat(16'hAAAA);
        rom_addr = 18'h0; rom_cs = 1'b1; #1;
        chk("late beats no ok", {31'd0, rom_ok}, 32'h0);
        chk("late beats data", rom_data, 32'h0);
        tick(); tick();

        run = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
